// File: rtl/serial_add_pkg.sv
// Shared types for the bit-serial adder sequencer.
// Holds the FSM encoding used by serial_add_seq.
package serial_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

endpackage

// File: rtl/serial_add_bit.sv
// Combinational 1-bit full adder cell driven LSB-first by serial_add_seq.
// Zero latency; no flow control of its own.
module serial_add_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one operand beat in, one bit pair per clock, one WIDTH-bit result out (out_ovf with SERIAL_ADD_OVF_EN).
// Latency: out_valid rises WIDTH clocks after the acceptance edge.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module serial_add_seq
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             out_ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fa_s, fa_cout, last_bit;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  serial_add_bit u_bit (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    res_d     = res_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    cnt_d     = cnt_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          carry_d = in_cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        carry_d = fa_cout;
        res_d   = {fa_s, res_q[WIDTH-1:1]};
        if (last_bit) begin
          // Result registers only change here, so they stay stable outside DONE.
          sum_d   = {fa_s, res_q[WIDTH-1:1]};
          cout_d  = fa_cout;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_cout;
`endif
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_sum  = sum_q;
  assign out_cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign out_ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq with a cycle-level behavioural model and literal checks.
module tb_serial_add_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef SERIAL_ADD_OVF_EN
  logic         out_ovf;
`endif

  int total = 0;
  int bad   = 0;
  logic chk_en = 1'b0;

  serial_add_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout)
`ifdef SERIAL_ADD_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: an accepted op yields in_a+in_b+in_cin exactly W edges later and holds until consumed.
  logic         m_busy = 1'b0;
  logic         m_done = 1'b0;
  int           m_left = 0;
  logic [W:0]   m_res = '0;
  logic         m_ovf = 1'b0;
  logic [W-1:0] m_sum_hold = '0;
  logic         m_cout_hold = 1'b0;
  logic         m_ovf_hold = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_sum_hold = '0;
      m_cout_hold = 1'b0;
      m_ovf_hold = 1'b0;
    end else if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 1'b0;
        m_done = 1'b1;
        m_sum_hold = m_res[W-1:0];
        m_cout_hold = m_res[W];
        m_ovf_hold = m_ovf;
      end
    end else if (in_valid) begin
      m_busy = 1'b1;
      m_left = W;
      m_res  = {1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_cin};
      m_ovf  = (in_a[W-1] == in_b[W-1]) && (m_res[W-1] != in_a[W-1]);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("mdl_in_ready", {31'd0, in_ready}, {31'd0, !m_busy && !m_done});
      check("mdl_out_valid", {31'd0, out_valid}, {31'd0, m_done});
      check("mdl_out_sum", {24'd0, out_sum}, {24'd0, m_sum_hold});
      check("mdl_out_cout", {31'd0, out_cout}, {31'd0, m_cout_hold});
`ifdef SERIAL_ADD_OVF_EN
      check("mdl_out_ovf", {31'd0, out_ovf}, {31'd0, m_ovf_hold});
`endif
    end
  end

  // Issue one op, wait for the result, check latency and literal values, then optionally consume.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W-1:0] exp_sum, input logic exp_cout,
                        input logic exp_ovf, input logic consume);
    int lat;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 4 * W) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, lat, W);
    check({name, "_sum"}, {24'd0, out_sum}, {24'd0, exp_sum});
    check({name, "_cout"}, {31'd0, out_cout}, {31'd0, exp_cout});
`ifdef SERIAL_ADD_OVF_EN
    check({name, "_ovf"}, {31'd0, out_ovf}, {31'd0, exp_ovf});
`else
    if (exp_ovf === 1'bx) $display("unexpected x in ovf expectation");
`endif
    if (consume) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_sum", {24'd0, out_sum}, 32'd0);
    check("rst_out_cout", {31'd0, out_cout}, 32'd0);

    run_op("t1", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1);
    run_op("t2", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    run_op("t3", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b1);
    run_op("t4", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b1);
    run_op("t4b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    run_op("t4c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 1'b1);
    run_op("t4d", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);

    // Stall in DONE with a competing operand beat offered.
    run_op("t5", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0, 1'b0);
    in_a = 8'hAA; in_b = 8'h55; in_cin = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t5_hold_sum", {24'd0, out_sum}, 32'h46);
      check("t5_hold_cout", {31'd0, out_cout}, 32'd0);
      check("t5_hold_in_ready", {31'd0, in_ready}, 32'd0);
      check("t5_hold_valid", {31'd0, out_valid}, 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("t5_idle_ready", {31'd0, in_ready}, 32'd1);
    check("t5_idle_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("t5_no_load", {31'd0, in_ready}, 32'd1);

    // Reset during RUN abandons the operation.
    in_a = 8'h33; in_b = 8'h44; in_cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_in_ready", {31'd0, in_ready}, 32'd1);
    check("t6_out_valid", {31'd0, out_valid}, 32'd0);
    check("t6_out_sum", {24'd0, out_sum}, 32'd0);
    check("t6_out_cout", {31'd0, out_cout}, 32'd0);
    run_op("t6_after", 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
